// File: rtl/cmprs_arb_pkg.sv
// Shared constants and state encoding for the compressor channel arbiter.
// Imported by the round-robin picker and the arbiter top.
package cmprs_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_RUN   = 2'd2,
    ST_GAP   = 2'd3
  } arb_state_e;

  localparam int GAP_CYCLES_DEF   = 4;
  localparam int TIMEOUT_BITS_DEF = 20;
  localparam int TIMEOUT_DEF      = 500000;

endpackage

// File: rtl/cmprs_arb_rr_pick.sv
// Combinational round-robin picker: first set request
// searching from last+1 and wrapping back to last.
module cmprs_arb_rr_pick
  import cmprs_arb_pkg::*;
#(
  parameter int NUM_CHN  = 4,
  parameter int CHN_BITS = 2
) (
  input  logic [NUM_CHN-1:0]  req,
  input  logic [CHN_BITS-1:0] last,
  output logic [NUM_CHN-1:0]  onehot,
  output logic [CHN_BITS-1:0] enc,
  output logic                any
);

  localparam int PW = CHN_BITS + 1;

  logic [PW-1:0]      shift;
  logic [PW-1:0]      pos;
  logic [NUM_CHN-1:0] rot;

  // Rotate requests so bit 0 is the channel after last, then take first hit
  always_comb begin
    shift  = {1'b0, last} + PW'(1);
    rot    = NUM_CHN'({req, req} >> shift);
    any    = 1'b0;
    pos    = '0;
    enc    = '0;
    onehot = '0;
    for (int i = 0; i < NUM_CHN; i++) begin
      if (!any && rot[i]) begin
        any = 1'b1;
        pos = shift + PW'(i);
        if (pos >= PW'(NUM_CHN)) begin
          pos = pos - PW'(NUM_CHN);
        end
      end
    end
    enc = pos[CHN_BITS-1:0];
    if (any) begin
      onehot = NUM_CHN'(1) << enc;
    end
  end

endmodule

// File: rtl/cmprs_chn_arbiter.sv
// Shares one compressor pipeline between NUM_CHN channels, round-robin.
// Define CMPRS_ARB_WDOG_EN to build the RUN watchdog and wdog_err.
module cmprs_chn_arbiter
  import cmprs_arb_pkg::*;
#(
  parameter int NUM_CHN      = 4,
  parameter int CHN_BITS     = 2,
  parameter int GAP_CYCLES   = GAP_CYCLES_DEF,
  parameter int TIMEOUT_BITS = TIMEOUT_BITS_DEF,
  parameter int TIMEOUT      = TIMEOUT_DEF
) (
  input  logic                mclk,
  input  logic                mrst_n,
  input  logic                arb_en,
  input  logic [NUM_CHN-1:0]  chn_en,
  input  logic [NUM_CHN-1:0]  frame_req,
  input  logic                frame_done,
  output logic [NUM_CHN-1:0]  pending,
  output logic [NUM_CHN-1:0]  grant,
  output logic [CHN_BITS-1:0] grant_chn,
  output logic                grant_valid,
  output logic                frame_start,
  output logic                force_flush,
  output logic [NUM_CHN-1:0]  req_dropped,
  output logic                wdog_err
);

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  arb_state_e          state_q, state_d;
  logic [NUM_CHN-1:0]  pending_q, pending_d;
  logic [NUM_CHN-1:0]  drop_q, drop_d;
  logic [NUM_CHN-1:0]  grant_q, grant_d;
  logic [CHN_BITS-1:0] grant_chn_q, grant_chn_d;
  logic [CHN_BITS-1:0] last_q, last_d;
  logic [GAP_W-1:0]    gap_q, gap_d;

  logic [NUM_CHN-1:0]  req_set;
  logic [NUM_CHN-1:0]  clr;
  logic [NUM_CHN-1:0]  pick_oh;
  logic [CHN_BITS-1:0] pick_enc;
  logic                pick_any;
  logic                enter_start;
  logic                chn_live;
  logic                flush;
  logic                err_set;
  logic                wdog_exp;

  cmprs_arb_rr_pick #(
    .NUM_CHN  (NUM_CHN),
    .CHN_BITS (CHN_BITS)
  ) u_pick (
    .req    (pending_q & chn_en),
    .last   (last_q),
    .onehot (pick_oh),
    .enc    (pick_enc),
    .any    (pick_any)
  );

  assign enter_start = (state_q == ST_IDLE) && arb_en && pick_any;
  assign chn_live    = |(chn_en & grant_q);

  // Pending latch: a new request beats any clear in the same cycle
  always_comb begin
    req_set = frame_req & chn_en & {NUM_CHN{arb_en}};
    clr     = ~chn_en | {NUM_CHN{~arb_en}};
    if (state_q == ST_START) begin
      clr = clr | grant_q;
    end
    pending_d = (pending_q & ~clr) | req_set;
    drop_d    = req_set & pending_q & ~clr;
  end

  // Next-state, grant bookkeeping and abort pulse
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    grant_chn_d = grant_chn_q;
    last_d      = last_q;
    gap_d       = gap_q;
    flush       = 1'b0;
    err_set     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (enter_start) begin
          state_d     = ST_START;
          grant_d     = pick_oh;
          grant_chn_d = pick_enc;
          last_d      = pick_enc;
        end
      end
      ST_START: begin
        if (!arb_en) begin
          state_d = ST_GAP;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (frame_done) begin
          state_d = ST_GAP;
        end else if (!arb_en || !chn_live) begin
          flush   = 1'b1;
          state_d = ST_GAP;
        end else if (wdog_exp) begin
          flush   = 1'b1;
          err_set = 1'b1;
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        if (gap_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q - GAP_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (state_d == ST_GAP && state_q != ST_GAP) begin
      grant_d     = '0;
      grant_chn_d = '0;
      gap_d       = GAP_W'(GAP_CYCLES - 1);
    end
  end

  // Arbiter state registers
  always_ff @(posedge mclk or negedge mrst_n) begin
    if (!mrst_n) begin
      state_q     <= ST_IDLE;
      pending_q   <= '0;
      drop_q      <= '0;
      grant_q     <= '0;
      grant_chn_q <= '0;
      last_q      <= CHN_BITS'(NUM_CHN - 1);
      gap_q       <= '0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      drop_q      <= drop_d;
      grant_q     <= grant_d;
      grant_chn_q <= grant_chn_d;
      last_q      <= last_d;
      gap_q       <= gap_d;
    end
  end

`ifdef CMPRS_ARB_WDOG_EN
  logic [TIMEOUT_BITS-1:0] wdog_q, wdog_d;
  logic                    wdog_err_q, wdog_err_d;

  assign wdog_exp = (state_q == ST_RUN) && (wdog_q == '0);

  // Watchdog reloads on grant, counts down only while RUN
  always_comb begin
    wdog_d = wdog_q;
    if (enter_start) begin
      wdog_d = TIMEOUT_BITS'(TIMEOUT);
    end else if (state_q == ST_RUN && wdog_q != '0) begin
      wdog_d = wdog_q - TIMEOUT_BITS'(1);
    end
    wdog_err_d = arb_en & (wdog_err_q | err_set);
  end

  // Watchdog registers
  always_ff @(posedge mclk or negedge mrst_n) begin
    if (!mrst_n) begin
      wdog_q     <= '0;
      wdog_err_q <= 1'b0;
    end else begin
      wdog_q     <= wdog_d;
      wdog_err_q <= wdog_err_d;
    end
  end

  assign wdog_err = wdog_err_q;
`else
  logic unused_wdog;

  assign wdog_exp    = 1'b0;
  assign wdog_err    = 1'b0;
  assign unused_wdog = ^{err_set, TIMEOUT_BITS'(TIMEOUT)};
`endif

  assign pending     = pending_q;
  assign grant       = grant_q;
  assign grant_chn   = grant_chn_q;
  assign grant_valid = (state_q == ST_START) || (state_q == ST_RUN);
  assign frame_start = (state_q == ST_START);
  assign force_flush = flush;
  assign req_dropped = drop_q;

endmodule
